// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button input path: long-press state
// encoding, board default timing constants and a counter-width helper.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } btn_state_e;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEBOUNCE_CYCLES = 1_000_000;   // 20 ms at 50 MHz
    localparam int LONG_CYCLES     = 50_000_000;  // 1 s at 50 MHz

    // Counter width for a modulus of n; never returns 0 so degenerate
    // parameter values still give a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button pin in, debounced level / event strobes / press count out.
// master = downstream logic plus pin source, slave = the debouncer.
interface button_debounce_if;
    logic       btn_pin;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    modport master (
        output btn_pin,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  press_count
    );

    modport slave (
        input  btn_pin,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output press_count
    );
endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
// Both stages clear to 0 under the synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1_q;
    logic s2_q;

    // Two back-to-back flops give metastability time to resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/button_debounce.sv
// Push-button front end: synchronise, debounce, then report press,
// release and long-press strobes together with a wrapping press count.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = button_debounce_pkg::DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = button_debounce_pkg::LONG_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    button_debounce_if.slave         bus
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW = cnt_width(LONG_CYCLES);

    logic          btn_s;
    logic          level_q,   level_d;
    logic [DW-1:0] db_cnt_q,  db_cnt_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;
    logic [7:0]    count_q,   count_d;
    logic          accept_rise;
    logic          accept_fall;

    btn_state_e    state_q;
    logic [LW-1:0] long_cnt_q;
    logic          long_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_pin),
        .q     (btn_s)
    );

    // Debounce counter runs only while the synchronised pin disagrees with
    // the accepted level; any agreement restarts it, so short glitches vanish.
    always_comb begin
        level_d     = level_q;
        db_cnt_d    = '0;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        if (btn_s != level_q) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                level_d     = btn_s;
                accept_rise = btn_s;
                accept_fall = ~btn_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d   = accept_rise;
        release_d = accept_fall;
        count_d   = count_q + {7'd0, accept_rise};
    end

    // Level, counter, strobes and press count all update on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    // Long-press FSM; an accepted fall always wins over the threshold so a
    // release on the threshold edge never produces a long strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RELEASED;
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (accept_rise) begin
                        state_q    <= PRESSED;
                        long_cnt_q <= '0;
                    end
                end
                PRESSED: begin
                    if (accept_fall) begin
                        state_q <= RELEASED;
                    end else if (long_cnt_q == LW'(LONG_CYCLES - 1)) begin
                        long_q  <= 1'b1;
                        state_q <= HELD;
                    end else begin
                        long_cnt_q <= long_cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (accept_fall) begin
                        state_q <= RELEASED;
                    end
                end
                default: state_q <= RELEASED;
            endcase
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.press_count   = count_q;
endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with short debounce/long times.
// The reference model decides acceptance by looking at a window of past pin
// samples and times long presses arithmetically from the press edge.
module tb_button_debounce;
    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    button_debounce_if bus ();

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic       win_q[$];
    logic       m_level;
    logic       m_press, m_release, m_long;
    logic [7:0] m_count;
    int         n;
    int         press_edge;
    bit         armed;
    logic [11:0] exp_vec;
    logic [11:0] obs_vec;

    assign obs_vec = {bus.btn_level, bus.press_pulse, bus.release_pulse,
                      bus.long_pulse, bus.press_count};

    task automatic model_clear();
        win_q = {};
        for (int i = 0; i < D + 1; i++) win_q.push_back(1'b0);
        m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
        m_count = 8'd0; n = 0; press_edge = 0; armed = 1'b0;
        exp_vec = '0;
    endtask

    // Drive the pin for one clock and advance the model by one edge.
    task automatic tick(input logic p);
        bit flip;
        bus.btn_pin = p;
        @(posedge clk);
        #1;
        n++;
        win_q.push_back(p);
        if (win_q.size() > D + 2) void'(win_q.pop_front());
        m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
        flip = 1'b1;
        for (int i = 0; i < D; i++) if (win_q[i] == m_level) flip = 1'b0;
        if (flip) begin
            m_level = ~m_level;
            if (m_level) begin
                m_press = 1'b1; m_count = m_count + 8'd1;
                press_edge = n; armed = 1'b1;
                $display("[TB] edge %0d press count=%0d", n, m_count);
            end else begin
                m_release = 1'b1; armed = 1'b0;
                $display("[TB] edge %0d release", n);
            end
        end
        if (armed && n == press_edge + L) begin
            m_long = 1'b1; armed = 1'b0;
            $display("[TB] edge %0d long press", n);
        end
        exp_vec = {m_level, m_press, m_release, m_long, m_count};
    endtask

    task automatic do_reset(input logic p);
        bus.btn_pin = p;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        bus.btn_pin = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (obs_vec !== 12'h000) begin
                tests_failed++;
                $display("[TB] FAIL reset_state got %h want 000", obs_vec);
            end
        end
        do_reset(1'b0);
    endtask

    task automatic test_clean_press();
        int seen_edge = -1;
        int pulses = 0;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(i >= 9);
            if (bus.press_pulse) begin pulses++; seen_edge = n; end
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL clean_press edge %0d got %h want %h", n, obs_vec, exp_vec);
            end
        end
        tests_run++;
        if (seen_edge != 15 || pulses != 1 || bus.press_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL clean_press_timing got edge %0d pulses %0d count %0d want edge 15 pulses 1 count 1",
                     seen_edge, pulses, bus.press_count);
        end
    endtask

    task automatic test_bounce();
        logic pat [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int seen_edge = -1;
        int pulses = 0;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick((i < 7) ? pat[i] : 1'b1);
            if (bus.press_pulse) begin pulses++; seen_edge = n; end
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL bounce edge %0d got %h want %h", n, obs_vec, exp_vec);
            end
        end
        // Steady high starts at edge 8, so the press lands at 8 + D + 1.
        tests_run++;
        if (seen_edge != 8 + D + 1 || pulses != 1 || bus.press_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL bounce_single got edge %0d pulses %0d count %0d want edge %0d pulses 1 count 1",
                     seen_edge, pulses, bus.press_count, 8 + D + 1);
        end
    endtask

    task automatic test_long_press();
        int p_edge = -1, l_edge = -1, r_edge = -1;
        int longs = 0;
        do_reset(1'b0);
        for (int i = 0; i < 41; i++) begin
            tick(i >= 1 && i < 31);
            if (bus.press_pulse) p_edge = n;
            if (bus.long_pulse) begin longs++; l_edge = n; end
            if (bus.release_pulse) r_edge = n;
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL long_press edge %0d got %h want %h", n, obs_vec, exp_vec);
            end
        end
        // Pin high from edge 2, low from edge 32.
        tests_run++;
        if (longs != 1 || p_edge != 7 || l_edge != p_edge + L || r_edge != 32 + D + 1) begin
            tests_failed++;
            $display("[TB] FAIL long_press_timing got press %0d long %0d x%0d release %0d want press 7 long %0d x1 release %0d",
                     p_edge, l_edge, longs, r_edge, 7 + L, 32 + D + 1);
        end
    endtask

    task automatic test_release_at_threshold();
        int r_edge = -1;
        int longs_a = 0, longs_b = 0;
        do_reset(1'b0);
        // Press accepted at edge 7; pin low from edge 12 gives the fall at 17 = 7 + L.
        for (int i = 0; i < 20; i++) begin
            tick(i >= 1 && i < 11);
            if (bus.long_pulse) longs_a++;
            if (bus.release_pulse) r_edge = n;
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL threshold_release edge %0d got %h want %h", n, obs_vec, exp_vec);
            end
        end
        tests_run++;
        if (longs_a != 0 || r_edge != 7 + L) begin
            tests_failed++;
            $display("[TB] FAIL threshold_release_result got long x%0d release %0d want long x0 release %0d",
                     longs_a, r_edge, 7 + L);
        end
        // A fresh press must time a full long period again from RELEASED.
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (bus.long_pulse) longs_b++;
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL threshold_repress edge %0d got %h want %h", n, obs_vec, exp_vec);
            end
        end
        tests_run++;
        if (longs_b != 1) begin
            tests_failed++;
            $display("[TB] FAIL threshold_repress_long got x%0d want x1", longs_b);
        end
    endtask

    task automatic test_count_wrap();
        int pulses = 0;
        do_reset(1'b0);
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 2 * (D + 2); i++) begin
                tick(i < D + 2);
                if (bus.press_pulse) pulses++;
                tests_run++;
                if (obs_vec !== exp_vec) begin
                    tests_failed++;
                    $display("[TB] FAIL count_wrap edge %0d got %h want %h", n, obs_vec, exp_vec);
                end
            end
            tests_run++;
            if (bus.press_count !== 8'((k + 1) % 256) || pulses != k + 1) begin
                tests_failed++;
                $display("[TB] FAIL count_wrap_value iter %0d got count %0d pulses %0d want count %0d pulses %0d",
                         k, bus.press_count, pulses, (k + 1) % 256, k + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen_edge = -1;
        do_reset(1'b0);
        for (int i = 0; i < 11; i++) begin
            tick(i >= 1 && i < 9);
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_pre edge %0d got %h want %h", n, obs_vec, exp_vec);
            end
        end
        // Pressed and two cycles into a release debounce: pulse reset, pin high.
        do_reset(1'b1);
        tests_run++;
        if (obs_vec !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_clear got %h want 000", obs_vec);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            if (bus.press_pulse && seen_edge < 0) seen_edge = n;
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_post edge %0d got %h want %h", n, obs_vec, exp_vec);
            end
        end
        tests_run++;
        if (seen_edge != D + 2 || bus.press_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_press got edge %0d count %0d want edge %0d count 1",
                     seen_edge, bus.press_count, D + 2);
        end
    endtask

    task automatic test_random();
        logic v = 1'b0;
        do_reset(1'b0);
        for (int r = 0; r < 60; r++) begin
            int len = $urandom_range(1, 16);
            v = ~v;
            for (int i = 0; i < len; i++) begin
                tick(v);
                tests_run++;
                if (obs_vec !== exp_vec) begin
                    tests_failed++;
                    $display("[TB] FAIL random edge %0d got %h want %h", n, obs_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.btn_pin = 1'b0;
        model_clear();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_at_threshold();
        test_count_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side counterpart to the LED blink driver: the board LED path drives a pin from a counter, and this block reads a mechanical push-button pin with a counter. It synchronises the raw pin and debounces it, then reports clean press, release and long-press events plus a running press count to downstream logic. Everything runs on the 50 MHz board clock; there is no other clock domain inside the block.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronised input must hold a new value before it is accepted (20 ms at 50 MHz).
- LONG_CYCLES, 50_000_000: cycles the accepted level must stay high before a long-press event fires (1 s at 50 MHz).
- clk  input  1  board clock, 50 MHz; all logic on posedge.
- rst_n  input  1  reset: one clock, synchronous, active-low.
- btn_pin  input  1  raw, asynchronous, bouncing button pin; 1 = pressed.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on debounced 0→1.
- release_pulse  output  1  one-cycle strobe on debounced 1→0.
- long_pulse  output  1  one-cycle strobe, at most once per press.
- press_count  output  8  number of accepted presses, wraps modulo 256.

## Operation
- **Synchroniser:** btn_pin passes through two flops, giving btn_s. Reset value of both flops is 0.
- **Debounce counter:** width is $clog2(DEBOUNCE_CYCLES).
  - On each edge where btn_s == btn_level, the counter is cleared to 0.
  - On each edge where btn_s != btn_level:
    - if the counter == DEBOUNCE_CYCLES-1, btn_level <= btn_s and the counter is cleared;
    - otherwise the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded completely.
- **Press/release strobes:**
  - press_pulse is high for exactly the single cycle in which btn_level first reads 1.
  - release_pulse is high for exactly the single cycle in which btn_level first reads 0.
  - Both strobes are registered.
- **Long-press state machine:** width of its counter is $clog2(LONG_CYCLES).
  - RELEASED: btn_level = 0. On an accepted rise, go to PRESSED and clear the long counter.
  - PRESSED: the long counter increments every cycle.
    - When it reaches LONG_CYCLES-1 with btn_level still 1, assert long_pulse for one cycle and go to HELD.
    - On an accepted fall, go to RELEASED.
  - HELD: long counter frozen. On an accepted fall, go to RELEASED.
- **Press count:** press_count increments in the same edge that raises press_pulse. 255 + 1 = 0.
- **Reset:** every register, both counters, all outputs and the synchroniser clear to 0, and the state goes to RELEASED.
  - Reset asserted mid-debounce or mid-hold abandons that activity.
  - If the pin is held high through reset, it is accepted as a new press DEBOUNCE_CYCLES+2 edges after rst_n rises.

## Timing
- **Latency:** let the pin settle before sampling edge k. btn_level, plus the matching press_pulse or release_pulse, is visible after edge k+DEBOUNCE_CYCLES+1.
  - That is, 2 synchroniser edges plus DEBOUNCE_CYCLES counting edges, with the first count at edge k+2.
- **Long press:** long_pulse is visible LONG_CYCLES edges after press_pulse, provided btn_level stays 1 throughout.
- **Simultaneous events:** an accepted fall on the same edge the long counter hits threshold gives release_pulse only; long_pulse stays 0.
- **Strobe exclusivity:** press_pulse and release_pulse are never high together.
- **Pulse width:** all strobes are exactly 1 cycle wide; there is no handshake and no back-pressure.

## Structure
- **Shared package:** holds the state encoding (RELEASED=2'd0, PRESSED=2'd1, HELD=2'd2) and the board default constants (CLK_HZ = 50_000_000, DEBOUNCE_CYCLES, LONG_CYCLES).
- **Sub-module:** sync_2ff, a generic 2-flop synchroniser with rst_n. It is instantiated once here and is reusable for other pin inputs.
- **Main module:** counters, FSM and strobe registers live in button_debounce itself.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=10.

1. **Clean press:** btn_pin 0→1 before edge 10 and held high → btn_level=1 and press_pulse=1 after edge 15 only; press_count=1.
2. **Bounce rejection:** pin toggles 1,0,1,0 on consecutive cycles, then stays 1 → no strobes during the bounce; a single press_pulse arrives 6 edges after the last toggle; press_count=1.
3. **Long press:** pin held high → long_pulse fires exactly once, 10 edges after press_pulse; no second pulse while still held. Releasing the pin → release_pulse once 6 edges later.
4. **Release at the long threshold:** release timed so btn_level falls on the threshold edge → release_pulse=1, long_pulse never asserted, state=RELEASED.
5. **Count wrap:** 256 clean press/release cycles → press_count goes 255 then 0, with press_pulse on each press.
6. **Reset mid-operation:** rst_n=0 for 1 cycle while pressed and mid-debounce → all outputs 0 on the next edge. With the pin still high, press_pulse comes 6 edges after rst_n returns to 1, and press_count=1.
